seq_alu: RTL and testbench

- Parametrised, registered successor to the team's 3-bit-opcode combinational ALU.
- Keeps the same eight-op add/sub/inc/dec/pass family, with opcode 7 redefined as a multi-cycle signed multiply.
- Adds a valid/ready handshake on input and output, a registered result and carry/overflow/zero flags.
- Sits between the operand sequencer and the accumulator stage of the neural datapath.

---
 rtl/seq_alu.sv | 84 ++++++++
 tb/tb_seq_alu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered add/sub/inc/dec/pass ALU with valid/ready handshake and
// an iterative radix-2 signed multiply on opcode 7.
module seq_alu #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           opcode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   y,
  output logic                 co,
  output logic                 ovf,
  output logic                 zero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, MUL} state_t;
  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [WIDTH-1:0]     x;
  logic                 cin, accept, last, ovf_d;
  logic [WIDTH:0]       s;
  logic [2*WIDTH-1:0]   pp, prod_d, y_d;
  assign in_ready = !rst && state_q == IDLE && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  always_comb begin
    x      = opcode < 3'd2 ? b : opcode < 3'd4 ? ~b : opcode == 3'd6 ? '1 : '0;
    cin    = opcode == 3'd1 || opcode == 3'd3 || opcode == 3'd5;
    s      = {1'b0, a} + {1'b0, x} + (WIDTH+1)'(cin);
    ovf_d  = (a[WIDTH-1] == x[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    y_d    = {{WIDTH{s[WIDTH-1]}}, s[WIDTH-1:0]};
    last   = cnt_q == CW'(WIDTH-1);
    // the multiplier MSB carries negative weight, so its partial product is subtracted
    pp     = mplier_q[0] ? (last ? -mcand_q : mcand_q) : '0;
    prod_d = acc_q + pp;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      out_valid <= 1'b0;
      y         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (state_q == MUL) begin
      acc_q    <= prod_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        state_q   <= IDLE;
        out_valid <= 1'b1;
        y         <= prod_d;
        co        <= 1'b0;
        ovf       <= 1'b0;
        zero      <= prod_d == '0;
      end
    end else if (accept && opcode == 3'd7) begin
      state_q   <= MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= {{WIDTH{a[WIDTH-1]}}, a};
      mplier_q  <= b;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      y         <= y_d;
      co        <= s[WIDTH];
      ovf       <= ovf_d;
      zero      <= s[WIDTH-1:0] == '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=16.
module tb_seq_alu;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, co, ovf, zero;
  logic [W-1:0] a = '0, b = '0;
  logic [2:0] opcode = '0;
  logic [2*W-1:0] y;
  typedef struct packed {logic [31:0] y; logic co; logic ovf; logic z;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, passed = 0;
  logic [2:0]  tv_op [7] = '{3'd0, 3'd3, 3'd2, 3'd6, 3'd5, 3'd4, 3'd1};
  logic [15:0] tv_a  [7] = '{16'h7FFF, 16'h0005, 16'h0000, 16'h8000, 16'hFFFF, 16'h1234, 16'hFFFF};
  logic [15:0] tv_b  [7] = '{16'h0001, 16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'hABCD, 16'hFFFF};
  exp_t        tv_e  [7] = '{'{32'hFFFF8000, 1'b0, 1'b1, 1'b0}, '{32'h00000000, 1'b1, 1'b0, 1'b1},
                             '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}, '{32'h00007FFF, 1'b1, 1'b1, 1'b0},
                             '{32'h00000000, 1'b1, 1'b0, 1'b1}, '{32'h00001234, 1'b0, 1'b0, 1'b0},
                             '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0}};

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready), .y(y), .co(co),
    .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [2:0] op, input logic [15:0] aa, input logic [15:0] bb);
    int sa, sb, sx, cin, r, u;
    exp_t m;
    sa  = int'($signed(aa));
    sb  = int'($signed(bb));
    sx  = op < 2 ? sb : op < 4 ? -sb - 1 : op == 6 ? -1 : 0;
    cin = (op == 1 || op == 3 || op == 5) ? 1 : 0;
    if (op == 7) begin
      r = sa * sb;
      m.y = r; m.co = 1'b0; m.ovf = 1'b0; m.z = (r == 0);
    end else begin
      r = sa + sx + cin;
      u = int'(aa) + (sx & 'hFFFF) + cin;
      m.y = {{16{r[15]}}, r[15:0]};
      m.co = u[16];
      m.ovf = (r > 32767) || (r < -32768);
      m.z = (r[15:0] == 16'h0000);
    end
    return m;
  endfunction

  // Presents one op from a negedge, returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [15:0] aa, input logic [15:0] bb, input exp_t ex);
    bit ok = 1'b0;
    in_valid = 1'b1; opcode = op; a = aa; b = bb;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1 ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0; a = $urandom; b = $urandom; opcode = $urandom;
    if (ok) q.push_back(ex);
    else begin
      checks++;
      $display("FAIL send: in_ready never rose for opcode %0d", op);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, y, co, ovf, zero} !== '0)
      $display("FAIL reset_outputs: got rdy=%b v=%b y=%h co=%b ovf=%b z=%b, want all 0", in_ready, out_valid, y, co, ovf, zero);
    else passed++;
    rst = 1'b0;
    #1 checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL reset_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_alu();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(tv_op[i], tv_a[i], tv_b[i], tv_e[i]);
      e = q.pop_front();
      checks++;
      if ({out_valid, y, co, ovf, zero} !== {1'b1, e})
        $display("FAIL alu_op%0d: got v=%b y=%h co=%b ovf=%b z=%b, want v=1 y=%h co=%b ovf=%b z=%b",
                 tv_op[i], out_valid, y, co, ovf, zero, e.y, e.co, e.ovf, e.z);
      else passed++;
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL alu_release: got v=%b, want 0", out_valid);
    else passed++;
  endtask

  task automatic test_mul();
    logic [15:0] ma [5] = '{16'hFFFD, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    logic [15:0] mb [5] = '{16'h0007, 16'h8000, 16'h0000, 16'h0000, 16'h0000};
    bit bad;
    for (int i = 2; i < 5; i++) begin ma[i] = $urandom; mb[i] = $urandom; end
    for (int i = 0; i < 5; i++) begin
      send(3'd7, ma[i], mb[i], i == 0 ? exp_t'({32'hFFFFFFEB, 3'b000}) :
                               i == 1 ? exp_t'({32'h40000000, 3'b000}) : model(3'd7, ma[i], mb[i]));
      bad = 1'b0;
      for (int k = 0; k < W; k++) begin
        if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad) $display("FAIL mul_busy%0d: out_valid or in_ready high before edge k+16, want both 0", i);
      else passed++;
      e = q.pop_front();
      checks++;
      if ({out_valid, y, co, ovf, zero} !== {1'b1, e})
        $display("FAIL mul%0d %h*%h: got v=%b y=%h co=%b ovf=%b z=%b, want v=1 y=%h co=%b ovf=%b z=%b",
                 i, ma[i], mb[i], out_valid, y, co, ovf, zero, e.y, e.co, e.ovf, e.z);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(3'd1, 16'd1, 16'd1, exp_t'({32'd3, 3'b000}));
    in_valid = 1'b1; opcode = 3'd0; a = 16'd4; b = 16'd5;
    for (int i = 0; i < 3; i++) begin
      #1 checks++;
      if ({out_valid, y, co, ovf, zero, in_ready} !== {1'b1, q[0], 1'b0})
        $display("FAIL hold%0d: got v=%b y=%h rdy=%b, want v=1 y=%h rdy=0", i, out_valid, y, in_ready, q[0].y);
      else passed++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 checks++;
    if (in_ready !== 1'b1) $display("FAIL hold_release_ready: got %b, want 1", in_ready);
    else passed++;
    void'(q.pop_front());
    q.push_back(model(3'd0, 16'd4, 16'd5));
    @(negedge clk);
    in_valid = 1'b0;
    e = q.pop_front();
    checks++;
    if ({out_valid, y, co, ovf, zero} !== {1'b1, e})
      $display("FAIL held_op: got v=%b y=%h, want v=1 y=%h", out_valid, y, e.y);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL held_release: got v=%b, want 0", out_valid);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] op;
    logic [15:0] ra, rb;
    time t0 = $time;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 6)); ra = $urandom; rb = $urandom;
      send(op, ra, rb, model(op, ra, rb));
      e = q.pop_front();
      checks++;
      if ({out_valid, y, co, ovf, zero} !== {1'b1, e})
        $display("FAIL b2b%0d op%0d %h,%h: got v=%b y=%h co=%b ovf=%b z=%b, want v=1 y=%h co=%b ovf=%b z=%b",
                 i, op, ra, rb, out_valid, y, co, ovf, zero, e.y, e.co, e.ovf, e.z);
      else passed++;
    end
    checks++;
    if ($time - t0 != 120) $display("FAIL b2b_throughput: got %0t for 12 ops, want 120", $time - t0);
    else passed++;
  endtask

  task automatic test_reset_mid_mul();
    bit bad = 1'b0;
    send(3'd7, 16'h1234, 16'h0F0F, model(3'd7, 16'h1234, 16'h0F0F));
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1 checks++;
    if ({in_ready, out_valid, y, co, ovf, zero} !== '0)
      $display("FAIL mid_mul_reset: got rdy=%b v=%b y=%h co=%b ovf=%b z=%b, want all 0", in_ready, out_valid, y, co, ovf, zero);
    else passed++;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    send(3'd0, 16'd2, 16'd3, exp_t'({32'd5, 3'b000}));
    e = q.pop_front();
    checks++;
    if ({out_valid, y, co, ovf, zero} !== {1'b1, e})
      $display("FAIL post_reset_add: got v=%b y=%h, want v=1 y=%h", out_valid, y, e.y);
    else passed++;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) $display("FAIL stale_valid: out_valid rose after reset with no op pending, want 0");
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mul();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end
endmodule
